// File: rtl/arm_ctrl_pkg.sv
// Shared control definitions for the multicycle decoder: state codes,
// datapath select constants and instruction class (Op) constants.
package arm_ctrl_pkg;

    // Main FSM states; codes 10-14 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd15
    } state_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Instruction classes from instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/writeback
// from Op/Funct and drives datapath selects plus unconditional write
// requests that condlogic later qualifies.
module mainfsm
    import arm_ctrl_pkg::*;
#(
    parameter bit TRAP_UNKNOWN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State
);

    state_t state, nextstate;

    // Only I (Funct[5]) and L/S (Funct[0]) steer the sequence
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    assign State = state;

    // State register with asynchronous return to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nextstate;
    end

    // Next-state selection; Op/Funct only matter in DECODE and MEMADR
    always_comb begin
        nextstate = S_FETCH;
        case (state)
            S_FETCH:  nextstate = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  nextstate = S_MEMADR;
                    OP_DP:   nextstate = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_B:    nextstate = S_BRANCH;
                    default: nextstate = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   nextstate = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nextstate = S_MEMWB;
            S_EXECUTER: nextstate = S_ALUWB;
            S_EXECUTEI: nextstate = S_ALUWB;
            S_UNKNOWN:  nextstate = TRAP_UNKNOWN ? S_UNKNOWN : S_FETCH;
            default:    nextstate = S_FETCH;
        endcase
    end

    // Moore outputs; write requests are held off while reset is asserted
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:    AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_EXTIMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
        end
    end

endmodule
